// File: rtl/link_sprite_pkg.sv
// Shared types and constants for the Link sprite overlay stage.
package link_sprite_pkg;

  localparam int unsigned SCREEN_W  = 640;
  localparam int unsigned SCREEN_H  = 480;
  localparam int unsigned SPR_W_DEF = 16;
  localparam int unsigned COORD_W   = 10;
  localparam int unsigned COLOR_W   = 4;
  localparam int unsigned IDX_W     = 4;
  // {dir[1:0], anim_frame, row, col}
  localparam int unsigned ROM_AW    = 3 + 2 * $clog2(SPR_W_DEF);

  typedef enum logic [1:0] {
    DIR_DOWN  = 2'd0,
    DIR_UP    = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_t;

  typedef struct packed {
    logic [COLOR_W-1:0] r;
    logic [COLOR_W-1:0] g;
    logic [COLOR_W-1:0] b;
  } rgb_t;

endpackage

// File: rtl/link_sprite_overlay_if.sv
// Pixel stream, sprite control and composited output of the overlay stage.
// Optional macro LINK_HIT_BLINK_EN adds the link_hurt control.
interface link_sprite_overlay_if;
  import link_sprite_pkg::*;

  logic [COORD_W-1:0] DrawX;
  logic [COORD_W-1:0] DrawY;
  logic               blank;
  logic               hs_in;
  logic               vs_in;
  logic [COLOR_W-1:0] bg_red;
  logic [COLOR_W-1:0] bg_green;
  logic [COLOR_W-1:0] bg_blue;
  logic [COORD_W-1:0] link_x;
  logic [COORD_W-1:0] link_y;
  logic [1:0]         link_dir;
  logic               link_moving;
`ifdef LINK_HIT_BLINK_EN
  logic               link_hurt;
`endif
  logic [COLOR_W-1:0] red;
  logic [COLOR_W-1:0] green;
  logic [COLOR_W-1:0] blue;
  logic               hs_out;
  logic               vs_out;

  modport master (
    output DrawX, DrawY, blank, hs_in, vs_in,
    output bg_red, bg_green, bg_blue,
    output link_x, link_y, link_dir, link_moving,
`ifdef LINK_HIT_BLINK_EN
    output link_hurt,
`endif
    input  red, green, blue, hs_out, vs_out
  );

  modport slave (
    input  DrawX, DrawY, blank, hs_in, vs_in,
    input  bg_red, bg_green, bg_blue,
    input  link_x, link_y, link_dir, link_moving,
`ifdef LINK_HIT_BLINK_EN
    input  link_hurt,
`endif
    output red, green, blue, hs_out, vs_out
  );

endinterface

// File: rtl/link_sprite_palette.sv
// Combinational 16-entry sprite palette.
module link_sprite_palette
  import link_sprite_pkg::*;
(
  input  logic [IDX_W-1:0] idx_i,
  output rgb_t             rgb_c
);

  // Index to colour.
  always_comb begin
    rgb_c.r = idx_i;
    rgb_c.g = ~idx_i;
    rgb_c.b = idx_i * 4'd3 + 4'd1;
  end

endmodule

// File: rtl/link_sprite_rom.sv
// Synchronous sprite index ROM; content is a procedural pose pattern.
module link_sprite_rom
  import link_sprite_pkg::*;
#(
  parameter int unsigned AW = ROM_AW
) (
  input  logic             clock,
  input  logic [AW-1:0]    address,
  output logic [IDX_W-1:0] q
);

  localparam int unsigned CW = (AW - 3) / 2;

  function automatic logic [IDX_W-1:0] rom_word(input logic [AW-1:0] a);
    logic [IDX_W-1:0] row;
    logic [IDX_W-1:0] col;
    logic [IDX_W-1:0] pose;
    row  = IDX_W'(a[2*CW-1 -: CW]);
    col  = IDX_W'(a[CW-1:0]);
    pose = IDX_W'({a[AW-1 -: 3], 1'b1});
    return row ^ col ^ pose;
  endfunction

  // Registered read, one cycle latency.
  always_ff @(posedge clock) begin
    q <= rom_word(address);
  end

endmodule

// File: rtl/link_sprite_overlay.sv
// Composites the Link sprite over the background stream, 3-cycle latency.
// Optional macro LINK_HIT_BLINK_EN: hurt blink (4 frames on / 4 off).
module link_sprite_overlay
  import link_sprite_pkg::*;
#(
  parameter int unsigned SPR_W       = SPR_W_DEF,
  parameter int unsigned SCALE_LOG2  = 1,
  parameter int unsigned ANIM_FRAMES = 8,
  parameter int unsigned TRANSP_IDX  = 0
) (
  input logic                  vga_clk,
  input logic                  reset,
  link_sprite_overlay_if.slave bus
);

  localparam int unsigned CW  = $clog2(SPR_W);
  localparam int unsigned AW  = 3 + 2 * CW;
  localparam int unsigned ACW = (ANIM_FRAMES > 1) ? $clog2(ANIM_FRAMES) : 1;
  localparam logic [COORD_W-1:0] SPAN = COORD_W'(SPR_W << SCALE_LOG2);

  logic               vs_prev_q;
  logic               vs_fall;
  logic [COORD_W-1:0] sx_q, sx_d, sy_q, sy_d;
  dir_t               dir_q, dir_d;
  logic [ACW-1:0]     anim_cnt_q, anim_cnt_d;
  logic               anim_frame_q, anim_frame_d;
`ifdef LINK_HIT_BLINK_EN
  logic               hurt_q, hurt_d;
  logic [2:0]         blink_q, blink_d;
`endif
  logic [COORD_W-1:0] dx_c, dy_c;
  logic               hit_c;
  logic [AW-1:0]      addr_c;
  logic [IDX_W-1:0]   rom_idx;
  logic               hit_d1_q, blank_d1_q, hs_d1_q, vs_d1_q;
  logic               opaque_d2_q, hit_d2_q, blank_d2_q, hs_d2_q, vs_d2_q;
  rgb_t               pal_c, pal_q, bg_c, rgb_d, rgb_q;
  logic               hs_q, vs_q;

  // A 1 must be seen before a 0 counts as an edge, so a low vs at release is ignored.
  assign vs_fall = vs_prev_q & ~bus.vs_in;

  // Per-frame shadow state and walk animation, updated on vs falling edge.
  always_comb begin
    sx_d         = sx_q;
    sy_d         = sy_q;
    dir_d        = dir_q;
    anim_cnt_d   = anim_cnt_q;
    anim_frame_d = anim_frame_q;
`ifdef LINK_HIT_BLINK_EN
    hurt_d       = hurt_q;
    blink_d      = blink_q;
`endif
    if (vs_fall) begin
      sx_d  = bus.link_x;
      sy_d  = bus.link_y;
      dir_d = dir_t'(bus.link_dir);
      if (!bus.link_moving) begin
        anim_cnt_d   = '0;
        anim_frame_d = 1'b0;
      end else if (anim_cnt_q == ACW'(ANIM_FRAMES - 1)) begin
        anim_cnt_d   = '0;
        anim_frame_d = ~anim_frame_q;
      end else begin
        anim_cnt_d = ACW'(anim_cnt_q + 1'b1);
      end
`ifdef LINK_HIT_BLINK_EN
      hurt_d  = bus.link_hurt;
      blink_d = 3'(blink_q + 1'b1);
`endif
    end
  end

  // Frame state registers.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      vs_prev_q    <= 1'b0;
      sx_q         <= '0;
      sy_q         <= '0;
      dir_q        <= DIR_DOWN;
      anim_cnt_q   <= '0;
      anim_frame_q <= 1'b0;
`ifdef LINK_HIT_BLINK_EN
      hurt_q       <= 1'b0;
      blink_q      <= '0;
`endif
    end else begin
      vs_prev_q    <= bus.vs_in;
      sx_q         <= sx_d;
      sy_q         <= sy_d;
      dir_q        <= dir_d;
      anim_cnt_q   <= anim_cnt_d;
      anim_frame_q <= anim_frame_d;
`ifdef LINK_HIT_BLINK_EN
      hurt_q       <= hurt_d;
      blink_q      <= blink_d;
`endif
    end
  end

  // Stage 0: box test and ROM address; unsigned wrap rejects pixels left/above.
  always_comb begin
    dx_c   = bus.DrawX - sx_q;
    dy_c   = bus.DrawY - sy_q;
    hit_c  = bus.blank && (dx_c < SPAN) && (dy_c < SPAN);
`ifdef LINK_HIT_BLINK_EN
    if (hurt_q && blink_q[2]) hit_c = 1'b0;
`endif
    addr_c = {dir_q, anim_frame_q, dy_c[SCALE_LOG2 +: CW], dx_c[SCALE_LOG2 +: CW]};
  end

  link_sprite_rom #(.AW(AW)) u_rom (
    .clock   (vga_clk),
    .address (addr_c),
    .q       (rom_idx)
  );

  link_sprite_palette u_pal (
    .idx_i (rom_idx),
    .rgb_c (pal_c)
  );

  // Stage 1: flags travelling alongside the ROM read.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      hit_d1_q   <= 1'b0;
      blank_d1_q <= 1'b0;
      hs_d1_q    <= 1'b1;
      vs_d1_q    <= 1'b1;
    end else begin
      hit_d1_q   <= hit_c;
      blank_d1_q <= bus.blank;
      hs_d1_q    <= bus.hs_in;
      vs_d1_q    <= bus.vs_in;
    end
  end

  // Stage 2: palette colour and flags, aligned with the background colour.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      pal_q       <= '0;
      opaque_d2_q <= 1'b0;
      hit_d2_q    <= 1'b0;
      blank_d2_q  <= 1'b0;
      hs_d2_q     <= 1'b1;
      vs_d2_q     <= 1'b1;
    end else begin
      pal_q       <= pal_c;
      opaque_d2_q <= (rom_idx != IDX_W'(TRANSP_IDX));
      hit_d2_q    <= hit_d1_q;
      blank_d2_q  <= blank_d1_q;
      hs_d2_q     <= hs_d1_q;
      vs_d2_q     <= vs_d1_q;
    end
  end

  assign bg_c = {bus.bg_red, bus.bg_green, bus.bg_blue};

  // Composite select: black outside active video, sprite over background.
  always_comb begin
    rgb_d = '0;
    if (blank_d2_q) rgb_d = (hit_d2_q && opaque_d2_q) ? pal_q : bg_c;
  end

  // Output register.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      rgb_q <= '0;
      hs_q  <= 1'b1;
      vs_q  <= 1'b1;
    end else begin
      rgb_q <= rgb_d;
      hs_q  <= hs_d2_q;
      vs_q  <= vs_d2_q;
    end
  end

  assign bus.red    = rgb_q.r;
  assign bus.green  = rgb_q.g;
  assign bus.blue   = rgb_q.b;
  assign bus.hs_out = hs_q;
  assign bus.vs_out = vs_q;

endmodule

// File: tb/tb_link_sprite_overlay.sv
// Randomized bench for link_sprite_overlay against a frame-level model.
module tb_link_sprite_overlay;
  import link_sprite_pkg::*;

  localparam int SPAN = 16 << 1;

  typedef struct {
    logic [11:0] rgb;
    logic [1:0]  sync;
    string       tag;
  } exp_t;

  logic vga_clk = 1'b0;
  logic reset   = 1'b0;
  int   total   = 0;
  int   bad     = 0;

  link_sprite_overlay_if bus ();

  link_sprite_overlay #(
    .SPR_W(16), .SCALE_LOG2(1), .ANIM_FRAMES(8), .TRANSP_IDX(0)
  ) dut (
    .vga_clk (vga_clk),
    .reset   (reset),
    .bus     (bus.slave)
  );

  always #5 vga_clk = ~vga_clk;

  // live sprite controls
  int lx, ly, ldir;
  bit lmov, lhurt;
  // model of per-frame state
  int m_sx, m_sy, m_dir, m_frame, m_cnt, m_blink;
  bit m_hurt, m_vs_prev;

  exp_t        exp_q[$];
  logic [11:0] bg_ring[4];
  int          slot;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] pal(input int i);
    return {4'(i), 4'(15 - i), 4'((3 * i + 1) % 16)};
  endfunction

  function automatic bit on_screen(input int x, input int y);
    return (x < int'(SCREEN_W)) && (y < int'(SCREEN_H));
  endfunction

  // Expected colour from sprite rules: 2x scaled 16x16 pose pattern.
  function automatic logic [11:0] expect_px(input int x, input int y, input bit bl,
                                            input logic [11:0] bgc);
    int dx, dy, idx;
    if (!bl) return 12'h000;
    dx = (x - m_sx) & 1023;
    dy = (y - m_sy) & 1023;
    if (dx >= SPAN || dy >= SPAN) return bgc;
`ifdef LINK_HIT_BLINK_EN
    if (m_hurt && m_blink >= 4) return bgc;
`endif
    idx = (dy / 2) ^ (dx / 2) ^ (m_dir * 4 + m_frame * 2 + 1);
    if (idx == 0) return bgc;
    return pal(idx);
  endfunction

  task automatic model_reset();
    m_sx = 0; m_sy = 0; m_dir = 0; m_frame = 0; m_cnt = 0;
    m_blink = 0; m_hurt = 0; m_vs_prev = 0;
  endtask

  // Check the output for the pixel driven 3 slots ago, then drive a new pixel.
  task automatic drive_now(input int x, input int y, input bit bl, input bit hs,
                           input bit vs, input logic [11:0] bgc);
    exp_t e;
    if (exp_q.size() == 3) begin
      e = exp_q.pop_front();
      chk({"rgb ", e.tag}, 32'({bus.red, bus.green, bus.blue}), 32'(e.rgb));
      chk({"sync ", e.tag}, 32'({bus.hs_out, bus.vs_out}), 32'(e.sync));
    end
    bus.DrawX       = 10'(x);
    bus.DrawY       = 10'(y);
    bus.blank       = bl;
    bus.hs_in       = hs;
    bus.vs_in       = vs;
    bus.link_x      = 10'(lx);
    bus.link_y      = 10'(ly);
    bus.link_dir    = 2'(ldir);
    bus.link_moving = lmov;
`ifdef LINK_HIT_BLINK_EN
    bus.link_hurt   = lhurt;
`endif
    bg_ring[slot % 4] = bgc;
    {bus.bg_red, bus.bg_green, bus.bg_blue} = bg_ring[(slot + 2) % 4];
    slot++;
    e.rgb  = expect_px(x, y, bl, bgc);
    e.sync = {hs, vs};
    e.tag  = $sformatf("(%0d,%0d)", x, y);
    exp_q.push_back(e);
    if (m_vs_prev && !vs) begin
      m_sx = lx; m_sy = ly; m_dir = ldir;
      if (lmov) begin
        m_cnt++;
        if (m_cnt == 8) begin m_cnt = 0; m_frame ^= 1; end
      end else begin
        m_cnt = 0; m_frame = 0;
      end
`ifdef LINK_HIT_BLINK_EN
      m_hurt  = lhurt;
      m_blink = (m_blink + 1) % 8;
`endif
    end
    m_vs_prev = vs;
  endtask

  task automatic step(input int x, input int y, input bit bl, input bit hs,
                      input bit vs, input logic [11:0] bgc);
    @(posedge vga_clk);
    #1;
    drive_now(x, y, bl, hs, vs, bgc);
  endtask

  task automatic vsync();
    repeat (3) step(0, 490, 1'b0, 1'b1, 1'b0, 12'($urandom));
    step(0, 495, 1'b0, 1'b1, 1'b1, 12'($urandom));
  endtask

  task automatic sweep(input int y, input int x0, input int x1, input bit fixed,
                       input logic [11:0] bgv);
    for (int x = x0; x <= x1; x++)
      step(x & 1023, y, on_screen(x & 1023, y), 1'($urandom_range(0, 1)), 1'b1,
           fixed ? bgv : 12'($urandom));
  endtask

  // Async reset between edges, then release with the pipeline expected idle.
  task automatic do_reset(input bit rel_vs);
    exp_t idle;
    reset = 1'b1;
    #1;
    chk("rst_rgb", 32'({bus.red, bus.green, bus.blue}), 32'h0);
    chk("rst_sync", 32'({bus.hs_out, bus.vs_out}), 32'h3);
    repeat (2) @(posedge vga_clk);
    #1;
    chk("rst_hold_rgb", 32'({bus.red, bus.green, bus.blue}), 32'h0);
    reset = 1'b0;
    model_reset();
    exp_q.delete();
    idle.rgb = 12'h000; idle.sync = 2'b11; idle.tag = "flush";
    exp_q.push_back(idle);
    exp_q.push_back(idle);
    drive_now(5, 5, 1'b1, 1'b1, rel_vs, 12'h0F0);
  endtask

  initial begin
    int x, y;
    bus.DrawX = '0; bus.DrawY = '0; bus.blank = 1'b0;
    bus.hs_in = 1'b1; bus.vs_in = 1'b1;
    bus.bg_red = '0; bus.bg_green = '0; bus.bg_blue = '0;
    bus.link_x = '0; bus.link_y = '0; bus.link_dir = '0; bus.link_moving = 1'b0;
`ifdef LINK_HIT_BLINK_EN
    bus.link_hurt = 1'b0;
`endif
    for (int i = 0; i < 4; i++) bg_ring[i] = 12'h000;
    lx = 0; ly = 0; ldir = 0; lmov = 0; lhurt = 0;
    #2;
    do_reset(1'b1);
    sweep(5, 0, 40, 1'b0, 12'h000);

    // Sprite at (100,100) facing down over a flat background.
    lx = 100; ly = 100; ldir = 0; lmov = 0;
    vsync();
    sweep(100, 95, 135, 1'b1, 12'h3A5);
    sweep(101, 95, 135, 1'b1, 12'h3A5);
    sweep(131, 98, 134, 1'b1, 12'h3A5);
    sweep(132, 98, 102, 1'b1, 12'h3A5);

    // Mid-frame move is held off until the next frame.
    lx = 200;
    sweep(110, 95, 240, 1'b0, 12'h000);
    vsync();
    sweep(110, 95, 240, 1'b0, 12'h000);

    // Walk animation over 17 moving frames, then stop.
    lx = 300; ly = 200; ldir = 3; lmov = 1;
    for (int f = 0; f < 17; f++) begin
      vsync();
      sweep(204, 298, 334, 1'b0, 12'h000);
    end
    lmov = 0;
    vsync();
    sweep(204, 298, 334, 1'b0, 12'h000);

    // Right and bottom screen edges clip only through blank.
    lx = 630; ly = 50; ldir = 2;
    vsync();
    sweep(50, 620, 665, 1'b0, 12'h000);
    sweep(60, 0, 8, 1'b0, 12'h000);
    lx = 300; ly = 470; ldir = 1;
    vsync();
    for (int r = 476; r <= 484; r++) sweep(r, 300, 306, 1'b0, 12'h000);

    // Reset mid-frame, released while vs is low; shadow returns to (0,0).
    lx = 400; ly = 300; ldir = 0;
    vsync();
    sweep(305, 398, 420, 1'b0, 12'h000);
    do_reset(1'b0);
    sweep(6, 0, 36, 1'b0, 12'h000);
    step(0, 490, 1'b0, 1'b1, 1'b1, 12'h000);
    vsync();
    sweep(305, 398, 434, 1'b0, 12'h000);

    // Randomized frames.
    for (int f = 0; f < 20; f++) begin
      lx = $urandom_range(0, 660); ly = $urandom_range(0, 500);
      ldir = $urandom_range(0, 3);
      lmov = ($urandom_range(0, 3) != 0);
      lhurt = 1'($urandom_range(0, 1));
      vsync();
      for (int k = 0; k < 60; k++) begin
        if (k == 30) lx = $urandom_range(0, 660);
        x = (m_sx - 4 + int'($urandom_range(0, 40))) & 1023;
        y = (m_sy - 4 + int'($urandom_range(0, 40))) & 1023;
        step(x, y, on_screen(x, y) && ($urandom_range(0, 9) != 0),
             1'($urandom_range(0, 1)), 1'b1, 12'($urandom));
      end
    end

    repeat (3) step(0, 490, 1'b0, 1'b1, 1'b1, 12'h000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
